coeff_bank_collect: RTL and testbench

Parametrised coefficient collector: accepts a per-job pixel count, then NTAP signed coefficients serially, and presents them as one parallel vector to the filter datapath. Each job's vector is held for exactly pixel_count output handshakes. NBANK banks let the next job's coefficients load while the current job is being consumed. Sits between the coefficient stream source and the convolution core.

---
 rtl/coeff_collect_pkg.sv | 21 ++
 rtl/coeff_bank_collect_if.sv | 45 ++++
 rtl/coeff_bank_collect_bank.sv | 85 ++++++++
 rtl/coeff_bank_collect.sv | 142 ++++++++++++++
 tb/tb_coeff_bank_collect.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/coeff_collect_pkg.sv
// Shared definitions for the coefficient bank collector: default sizes,
// load FSM state encoding and the width rule for the optional tap sum
// (enabled with the COEFF_BANK_SUM_EN macro).
package coeff_collect_pkg;

   localparam int NTAP_DEF  = 9;
   localparam int CW_DEF    = 9;
   localparam int PCW_DEF   = 16;
   localparam int NBANK_DEF = 2;

   typedef enum logic [0:0] {
      LD_IDLE  = 1'b0,
      LD_COEFF = 1'b1
   } ld_state_e;

   // A sum of ntap values of cw bits needs clog2(ntap) guard bits.
   function automatic int sum_w(input int ntap, input int cw);
      return cw + $clog2(ntap);
   endfunction

endpackage

// File: rtl/coeff_bank_collect_if.sv
// Handshake bundle between the coefficient source, the collector and the
// convolution core. coeffs_sum exists only when COEFF_BANK_SUM_EN is defined.
interface coeff_bank_collect_if
   import coeff_collect_pkg::*;
#(
   parameter int NTAP = NTAP_DEF,
   parameter int CW   = CW_DEF,
   parameter int PCW  = PCW_DEF,
   parameter int SW   = sum_w(NTAP, CW)
);

   logic                  pixel_count_valid;
   logic                  pixel_count_ready;
   logic [PCW-1:0]        pixel_count;

   logic                  coeff_valid;
   logic                  coeff_ready;
   logic signed [CW-1:0]  coeff_data;

   logic                  coeffs_valid;
   logic                  coeffs_ready;
   logic signed [CW-1:0]  coeffs_data [NTAP];
`ifdef COEFF_BANK_SUM_EN
   logic signed [SW-1:0]  coeffs_sum;
`endif

   // Collector side
   modport slave (
      input  pixel_count_valid, pixel_count, coeff_valid, coeff_data, coeffs_ready,
`ifdef COEFF_BANK_SUM_EN
      output coeffs_sum,
`endif
      output pixel_count_ready, coeff_ready, coeffs_valid, coeffs_data
   );

   // Source / sink side
   modport master (
      output pixel_count_valid, pixel_count, coeff_valid, coeff_data, coeffs_ready,
`ifdef COEFF_BANK_SUM_EN
      input  coeffs_sum,
`endif
      input  pixel_count_ready, coeff_ready, coeffs_valid, coeffs_data
   );

endinterface

// File: rtl/coeff_bank_collect_bank.sv
// One coefficient bank: tap registers, remaining-pixel counter, occupancy
// flags and (with COEFF_BANK_SUM_EN) the running sum of the loaded taps.
module coeff_bank
   import coeff_collect_pkg::*;
#(
   parameter int NTAP = NTAP_DEF,
   parameter int CW   = CW_DEF,
   parameter int PCW  = PCW_DEF,
   parameter int IW   = $clog2(NTAP),
   parameter int SW   = sum_w(NTAP, CW)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 claim,
   input  logic [PCW-1:0]       load_count,
   input  logic                 wr_en,
   input  logic [IW-1:0]        tap_idx,
   input  logic signed [CW-1:0] wr_data,
   input  logic                 commit,
   input  logic                 consume,
   output logic                 free,
   output logic                 full,
   output logic                 last,
`ifdef COEFF_BANK_SUM_EN
   output logic signed [SW-1:0] sum,
`endif
   output logic signed [CW-1:0] taps [NTAP]
);

   logic [PCW-1:0] remaining;
   logic           busy;
   logic           has_pixels;

   assign has_pixels = (remaining != '0);
   assign last       = full && (remaining == PCW'(1));
   assign free       = !busy;

   // Job length: captured on claim, counted down by each consumed vector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         remaining <= '0;
      else if (claim)   remaining <= load_count;
      else if (consume) remaining <= remaining - 1'b1;
   end

   // Occupancy: busy from claim until the last vector leaves; a zero-length
   // job releases the bank as soon as its taps are complete
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
         full <= 1'b0;
      end else if (claim) begin
         busy <= 1'b1;
      end else if (commit) begin
         busy <= has_pixels;
         full <= has_pixels;
      end else if (consume && last) begin
         busy <= 1'b0;
         full <= 1'b0;
      end
   end

   // Tap registers, written one at a time in tap order
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NTAP; i++) taps[i] <= '0;
      end else begin
         for (int i = 0; i < NTAP; i++)
            if (wr_en && tap_idx == IW'(i)) taps[i] <= wr_data;
      end
   end

`ifdef COEFF_BANK_SUM_EN
   function automatic logic signed [SW-1:0] sext(input logic signed [CW-1:0] v);
      return {{(SW-CW){v[CW-1]}}, v};
   endfunction

   // Running tap sum, restarted when the bank is claimed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       sum <= '0;
      else if (claim) sum <= '0;
      else if (wr_en) sum <= sum + sext(wr_data);
   end
`endif

endmodule

// File: rtl/coeff_bank_collect.sv
// Coefficient collector top: serial tap loading into NBANK rotating banks,
// parallel presentation of the oldest full bank once per pixel.
// Optional feature macro: COEFF_BANK_SUM_EN (adds coeffs_sum).
module coeff_bank_collect
   import coeff_collect_pkg::*;
#(
   parameter int NTAP  = NTAP_DEF,
   parameter int CW    = CW_DEF,
   parameter int PCW   = PCW_DEF,
   parameter int NBANK = NBANK_DEF
)(
   input logic              clk,
   input logic              rst,
   coeff_bank_collect_if.slave bus
);

   localparam int IW = $clog2(NTAP);
   localparam int PW = $clog2(NBANK);
   localparam int SW = sum_w(NTAP, CW);

   ld_state_e       state, state_nx;
   logic            run;
   logic [IW-1:0]   idx;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic            job_zero;

   logic            pc_ready, claim, wr_en, commit, consume;
   logic [NBANK-1:0] bank_free, bank_full, bank_last;
   logic [NBANK-1:0] bank_claim, bank_wr, bank_commit, bank_consume;
   logic signed [CW-1:0] bank_taps [NBANK][NTAP];
`ifdef COEFF_BANK_SUM_EN
   logic signed [SW-1:0] bank_sum [NBANK];
`endif

   // Held low through reset so the source sees no ready until released
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run <= 1'b0;
      else      run <= 1'b1;
   end

   // Load FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= LD_IDLE;
      else      state <= state_nx;
   end

   // Load FSM next state and strobes; readies depend only on registers
   always_comb begin
      state_nx = state;
      pc_ready = 1'b0;
      claim    = 1'b0;
      wr_en    = 1'b0;
      commit   = 1'b0;
      case (state)
         LD_IDLE: begin
            pc_ready = run && bank_free[wr_ptr];
            if (bus.pixel_count_valid && pc_ready) begin
               claim    = 1'b1;
               state_nx = LD_COEFF;
            end
         end
         LD_COEFF: begin
            if (bus.coeff_valid) begin
               wr_en = 1'b1;
               if (idx == IW'(NTAP - 1)) begin
                  commit   = 1'b1;
                  state_nx = LD_IDLE;
               end
            end
         end
         default: state_nx = LD_IDLE;
      endcase
   end

   // Tap index and zero-length marker for the job being loaded; a
   // zero-length job leaves the write pointer in place so the read pointer
   // never lands on a bank that will not be presented
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx      <= '0;
         job_zero <= 1'b0;
         wr_ptr   <= '0;
      end else begin
         if (claim) begin
            idx      <= '0;
            job_zero <= (bus.pixel_count == '0);
         end else if (wr_en) begin
            idx <= idx + 1'b1;
         end
         if (commit && !job_zero) wr_ptr <= wr_ptr + 1'b1;
      end
   end

   assign consume = bus.coeffs_valid && bus.coeffs_ready;

   // Read pointer steps past a bank once its final vector is taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           rd_ptr <= '0;
      else if (consume && bank_last[rd_ptr]) rd_ptr <= rd_ptr + 1'b1;
   end

   assign bank_claim   = NBANK'(claim)   << wr_ptr;
   assign bank_wr      = NBANK'(wr_en)   << wr_ptr;
   assign bank_commit  = NBANK'(commit)  << wr_ptr;
   assign bank_consume = NBANK'(consume) << rd_ptr;

   for (genvar g = 0; g < NBANK; g++) begin : g_bank
      coeff_bank #(
         .NTAP (NTAP),
         .CW   (CW),
         .PCW  (PCW),
         .IW   (IW),
         .SW   (SW)
      ) u_bank (
         .clk        (clk),
         .rst        (rst),
         .claim      (bank_claim[g]),
         .load_count (bus.pixel_count),
         .wr_en      (bank_wr[g]),
         .tap_idx    (idx),
         .wr_data    (bus.coeff_data),
         .commit     (bank_commit[g]),
         .consume    (bank_consume[g]),
         .free       (bank_free[g]),
         .full       (bank_full[g]),
         .last       (bank_last[g]),
`ifdef COEFF_BANK_SUM_EN
         .sum        (bank_sum[g]),
`endif
         .taps       (bank_taps[g])
      );
   end

   assign bus.pixel_count_ready = pc_ready;
   assign bus.coeff_ready       = (state == LD_COEFF);
   assign bus.coeffs_valid      = bank_full[rd_ptr];
   assign bus.coeffs_data       = bank_taps[rd_ptr];
`ifdef COEFF_BANK_SUM_EN
   assign bus.coeffs_sum        = bank_sum[rd_ptr];
`endif

endmodule

// File: tb/tb_coeff_bank_collect.sv
// Directed bench for coeff_bank_collect.
`timescale 1ns/1ps
module tb_coeff_bank_collect;
   import coeff_collect_pkg::*;

   localparam int NTAP  = 9;
   localparam int CW    = 9;
   localparam int PCW   = 16;
   localparam int NBANK = 2;
   localparam int LIMIT = 500;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   coeff_bank_collect_if #(.NTAP(NTAP), .CW(CW), .PCW(PCW)) bus ();

   coeff_bank_collect #(.NTAP(NTAP), .CW(CW), .PCW(PCW), .NBANK(NBANK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cv [NTAP];

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int base, input int step);
      for (int i = 0; i < NTAP; i++) cv[i] = base + i * step;
   endtask

   task automatic send_count(input int c);
      int t;
      t = 0;
      bus.pixel_count_valid = 1'b1;
      bus.pixel_count       = PCW'(c);
      while (bus.pixel_count_ready !== 1'b1 && t < LIMIT) begin
         tick();
         t++;
      end
      n_vec++;
      assert (t < LIMIT) else begin
         n_err++;
         $error("FAIL count_handshake: waited %0d cycles, limit %0d", t, LIMIT);
      end
      tick();
      bus.pixel_count_valid = 1'b0;
   endtask

   task automatic send_coeffs(input int n);
      int t;
      for (int k = 0; k < n; k++) begin
         t = 0;
         bus.coeff_valid = 1'b1;
         bus.coeff_data  = CW'(cv[k]);
         while (bus.coeff_ready !== 1'b1 && t < LIMIT) begin
            tick();
            t++;
         end
         n_vec++;
         assert (t < LIMIT) else begin
            n_err++;
            $error("FAIL coeff_handshake: tap %0d waited %0d cycles", k, t);
         end
         tick();
      end
      bus.coeff_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int vc, a_cnt, b_cnt, a_last, b_first, pr_first, cyc, xf, bad, r;
`ifdef COEFF_BANK_SUM_EN
      int s;
`endif
      bus.pixel_count_valid = 1'b0;
      bus.pixel_count       = '0;
      bus.coeff_valid       = 1'b0;
      bus.coeff_data        = '0;
      bus.coeffs_ready      = 1'b0;

      // Reset state
      #2;
      chk("rst_pc_ready", bus.pixel_count_ready, 0);
      chk("rst_coeff_ready", bus.coeff_ready, 0);
      chk("rst_coeffs_valid", bus.coeffs_valid, 0);
      chk("rst_data0", bus.coeffs_data[0], 0);
      chk("rst_data8", bus.coeffs_data[8], 0);
      tick();
      tick();
      #2 rst = 1'b1;
      tick();
      chk("post_rst_pc_ready", bus.pixel_count_ready, 1);

      // Basic job: count 3, taps 0..8
      bus.coeffs_ready = 1'b1;
      send_count(3);
      fill(0, 1);
      send_coeffs(NTAP);
      chk("basic_valid", bus.coeffs_valid, 1);
      for (int i = 0; i < NTAP; i++) chk("basic_data", bus.coeffs_data[i], i);
      vc = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus.coeffs_valid === 1'b1) vc++;
         tick();
      end
      chk("basic_valid_cycles", vc, 3);

      // Signed extremes
      cv[0] = -256; cv[1] = 255; cv[2] = -1; cv[3] = 0; cv[4] = 1;
      cv[5] = -128; cv[6] = 127; cv[7] = -256; cv[8] = 255;
      send_count(1);
      send_coeffs(NTAP);
      chk("signed_valid", bus.coeffs_valid, 1);
      for (int i = 0; i < NTAP; i++) chk("signed_data", bus.coeffs_data[i], cv[i]);
`ifdef COEFF_BANK_SUM_EN
      chk("signed_sum", bus.coeffs_sum, -3);
`endif
      tick();
      chk("signed_done", bus.coeffs_valid, 0);
`ifdef COEFF_BANK_SUM_EN
      fill(-256, 0);
      send_count(1);
      send_coeffs(NTAP);
      s = 0;
      for (int i = 0; i < NTAP; i++) s += cv[i];
      chk("sum_min", bus.coeffs_sum, s);
      chk("sum_min_const", bus.coeffs_sum, -2304);
      tick();
`endif

      // Double buffering: A (100 pixels) then B (2 pixels), C waits for A
      send_count(100);
      fill(10, 1);
      send_coeffs(NTAP);
      chk("dbl_a_valid", bus.coeffs_valid, 1);
      chk("dbl_a_data8", bus.coeffs_data[8], 18);
      send_count(2);
      fill(-1, -1);
      send_coeffs(NTAP);
      chk("dbl_full_stall", bus.pixel_count_ready, 0);
      bus.pixel_count_valid = 1'b1;
      bus.pixel_count       = PCW'(1);
      cyc = 0; a_cnt = 0; b_cnt = 0; a_last = -1; b_first = -1; pr_first = -1;
      while (cyc < 300 && b_cnt < 2) begin
         if (bus.coeffs_valid === 1'b1 && bus.coeffs_data[0] == 10) begin
            a_cnt++;
            a_last = cyc;
         end
         if (bus.coeffs_valid === 1'b1 && bus.coeffs_data[0] == -1) begin
            b_cnt++;
            if (b_first < 0) b_first = cyc;
         end
         if (bus.pixel_count_ready === 1'b1 && pr_first < 0) pr_first = cyc;
         tick();
         if (pr_first >= 0) bus.pixel_count_valid = 1'b0;
         cyc++;
      end
      bus.pixel_count_valid = 1'b0;
      chk("dbl_a_remaining", a_cnt, 90);
      chk("dbl_b_count", b_cnt, 2);
      chk("dbl_no_bubble", b_first, a_last + 1);
      chk("dbl_c_claim_cycle", pr_first, b_first);
      fill(50, 1);
      send_coeffs(NTAP);
      chk("dbl_c_valid", bus.coeffs_valid, 1);
      chk("dbl_c_data0", bus.coeffs_data[0], 50);
      tick();
      chk("dbl_c_done", bus.coeffs_valid, 0);

      // Back-pressure: count 5 under a random ready
      bus.coeffs_ready = 1'b0;
      send_count(5);
      fill(100, 1);
      send_coeffs(NTAP);
      chk("bp_valid", bus.coeffs_valid, 1);
      xf = 0; bad = 0; cyc = 0;
      while (xf < 5 && cyc < 80) begin
         r = (cyc < 30) ? int'($urandom_range(0, 1)) : 1;
         bus.coeffs_ready = r[0];
         if (bus.coeffs_valid === 1'b1) begin
            if (bus.coeffs_data[0] != 100 || bus.coeffs_data[8] != 108) bad++;
            if (r[0]) xf++;
         end else begin
            bad++;
         end
         tick();
         cyc++;
      end
      bus.coeffs_ready = 1'b1;
      chk("bp_transfers", xf, 5);
      chk("bp_stable", bad, 0);
      chk("bp_done", bus.coeffs_valid, 0);

      // Zero-count job followed by a one-pixel job
      send_count(0);
      fill(200, 1);
      send_coeffs(NTAP);
      chk("zero_not_shown", bus.coeffs_valid, 0);
      tick();
      chk("zero_still_idle", bus.coeffs_valid, 0);
      send_count(1);
      fill(30, 1);
      send_coeffs(NTAP);
      chk("zero_next_valid", bus.coeffs_valid, 1);
      chk("zero_next_data0", bus.coeffs_data[0], 30);
      chk("zero_next_data8", bus.coeffs_data[8], 38);
      tick();
      chk("zero_next_done", bus.coeffs_valid, 0);

      // Asynchronous reset in the middle of a load
      send_count(2);
      fill(70, 1);
      send_coeffs(4);
      chk("mid_coeff_ready", bus.coeff_ready, 1);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_coeff_ready", bus.coeff_ready, 0);
      chk("mid_rst_pc_ready", bus.pixel_count_ready, 0);
      chk("mid_rst_valid", bus.coeffs_valid, 0);
      chk("mid_rst_data0", bus.coeffs_data[0], 0);
      tick();
      #2 rst = 1'b1;
      tick();
      chk("mid_rel_pc_ready", bus.pixel_count_ready, 1);
      send_count(1);
      fill(80, 1);
      send_coeffs(NTAP);
      chk("fresh_valid", bus.coeffs_valid, 1);
      chk("fresh_data0", bus.coeffs_data[0], 80);
      chk("fresh_data8", bus.coeffs_data[8], 88);
      tick();
      chk("fresh_done", bus.coeffs_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
